ctrl_pipe: RTL and testbench

- Parametrised successor to the per-stage combinational control decoders.
- Decodes the D-stage instruction once into a control word, then carries it through NSTAGE pipeline registers (E, M, W, ...).
- Tnew counts down in every stage; Tuse-based stall request for D is generated from it.
- Sits beside the datapath pipeline registers in the MIPS core and replaces the separate E/M/W decoders.

---
 rtl/ctrl_pipe_if.sv | 36 +++
 rtl/ctrl_pipe.sv | 188 ++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: bundle between the decode-stage control pipeline and the core.
//   master (core side) drives: instr_D, valid_D, stall_ext, flush_E
//   slave  (ctrl_pipe)  drives: stall_D, instr_s, regwrite_s, waddr_s, tnew_s,
//                               memwrite_M, memtoreg_M, size_M, ldsign_M, link_M
// Per-stage outputs are packed; slice k belongs to stage k (0 = E).
interface ctrl_pipe_if #(
    parameter int NSTAGE = 3,
    parameter int TW     = 2
);
    logic [31:0]          instr_D;
    logic                 valid_D;
    logic                 stall_ext;
    logic                 flush_E;
    logic                 stall_D;
    logic [32*NSTAGE-1:0] instr_s;
    logic [NSTAGE-1:0]    regwrite_s;
    logic [5*NSTAGE-1:0]  waddr_s;
    logic [TW*NSTAGE-1:0] tnew_s;
    logic                 memwrite_M;
    logic                 memtoreg_M;
    logic [1:0]           size_M;
    logic                 ldsign_M;
    logic                 link_M;

    modport master (
        output instr_D, valid_D, stall_ext, flush_E,
        input  stall_D, instr_s, regwrite_s, waddr_s, tnew_s,
               memwrite_M, memtoreg_M, size_M, ldsign_M, link_M
    );

    modport slave (
        input  instr_D, valid_D, stall_ext, flush_E,
        output stall_D, instr_s, regwrite_s, waddr_s, tnew_s,
               memwrite_M, memtoreg_M, size_M, ldsign_M, link_M
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes the D-stage instruction once into a control word and
// carries it through NSTAGE pipeline registers (E, M, W, ...). Tnew counts
// down as the word moves; D-stage stall is derived from Tnew vs. Tuse.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-high reset, every stage becomes a bubble
//   bus   - ctrl_pipe_if slave: D-stage inputs, stall_D, per-stage controls
//           and the memory controls of stage MEM_STAGE (*_M)
module ctrl_pipe #(
    parameter int NSTAGE    = 3,
    parameter int MEM_STAGE = 1,
    parameter int TW        = 2
) (
    input  logic        clk,
    input  logic        reset,
    ctrl_pipe_if.slave  bus
);
    typedef struct packed {
        logic [31:0]   instr;
        logic          regwrite;
        logic [4:0]    waddr;
        logic [TW-1:0] tnew;
        logic          memwrite;
        logic          memtoreg;
        logic [1:0]    size;
        logic          ldsign;
        logic          link;
    } ctrl_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e,
                           OP_LUI = 6'h0f, OP_LB = 6'h20, OP_LH = 6'h21,
                           OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25,
                           OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                           F_SLLV = 6'h04, F_SRLV = 6'h06, F_JR = 6'h08,
                           F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21,
                           F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT = 6'h2a, F_SLTU = 6'h2b;

    ctrl_t   r_stage [NSTAGE];
    ctrl_t   w_next  [NSTAGE];
    ctrl_t   w_dec;
    logic    w_wen, w_rs_use, w_rt_use, w_rs_hit, w_rt_hit, w_hazard, w_stall;
    logic [4:0]    w_wsel;
    logic [TW-1:0] w_rs_tuse, w_rt_tuse, w_rs_tnew, w_rt_tnew;

    wire [5:0] w_op    = bus.instr_D[31:26];
    wire [4:0] w_rs    = bus.instr_D[25:21];
    wire [4:0] w_rt    = bus.instr_D[20:16];
    wire [4:0] w_rd    = bus.instr_D[15:11];
    wire [5:0] w_funct = bus.instr_D[5:0];

    // Decode: control word plus which operands are read and when (Tuse).
    always_comb begin
        w_dec       = '0;
        w_dec.instr = bus.instr_D;
        w_wen       = 1'b0;
        w_wsel      = 5'd0;
        w_rs_use    = 1'b0;
        w_rt_use    = 1'b0;
        w_rs_tuse   = '0;
        w_rt_tuse   = '0;
        case (w_op)
            OP_SPECIAL: begin
                case (w_funct)
                    F_ADDU, F_SUBU, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLLV, F_SRLV: begin
                        w_wen = 1'b1; w_wsel = w_rd; w_dec.tnew = TW'(1);
                        w_rs_use = 1'b1; w_rs_tuse = TW'(1);
                        w_rt_use = 1'b1; w_rt_tuse = TW'(1);
                    end
                    // constant shifts read only rt
                    F_SLL, F_SRL, F_SRA: begin
                        w_wen = 1'b1; w_wsel = w_rd; w_dec.tnew = TW'(1);
                        w_rt_use = 1'b1; w_rt_tuse = TW'(1);
                    end
                    F_JR: begin
                        w_rs_use = 1'b1;
                    end
                    F_JALR: begin
                        w_wen = 1'b1; w_wsel = w_rd; w_dec.link = 1'b1;
                        w_rs_use = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_wen = 1'b1; w_wsel = w_rt; w_dec.tnew = TW'(1);
                w_rs_use = (w_op != OP_LUI); w_rs_tuse = TW'(1);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                w_wen = 1'b1; w_wsel = w_rt; w_dec.tnew = TW'(2);
                w_dec.memtoreg = 1'b1;
                w_dec.size     = (w_op == OP_LW) ? 2'd2 :
                                 (w_op == OP_LH || w_op == OP_LHU) ? 2'd1 : 2'd0;
                w_dec.ldsign   = (w_op == OP_LB || w_op == OP_LH);
                w_rs_use = 1'b1; w_rs_tuse = TW'(1);
            end
            OP_SB, OP_SH, OP_SW: begin
                w_dec.memwrite = 1'b1;
                w_dec.size     = (w_op == OP_SW) ? 2'd2 : (w_op == OP_SH) ? 2'd1 : 2'd0;
                w_rs_use = 1'b1; w_rs_tuse = TW'(1);
                w_rt_use = 1'b1; w_rt_tuse = TW'(2);
            end
            OP_JAL: begin
                w_wen = 1'b1; w_wsel = 5'd31; w_dec.link = 1'b1;
            end
            OP_REGIMM: begin
                w_rs_use = 1'b1;
                // bgezal / bltzal link whether or not the branch is taken
                if (w_rt == 5'b10001 || w_rt == 5'b10000) begin
                    w_wen = 1'b1; w_wsel = 5'd31; w_dec.link = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin
                w_rs_use = 1'b1;
                w_rt_use = 1'b1;
            end
            default: ;
        endcase
        w_dec.waddr    = w_wsel;
        w_dec.regwrite = w_wen && (w_wsel != 5'd0);
    end

    // Youngest matching producer wins: scan oldest to youngest, last hit sticks.
    always_comb begin
        w_rs_hit  = 1'b0;
        w_rt_hit  = 1'b0;
        w_rs_tnew = '0;
        w_rt_tnew = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (r_stage[k].regwrite && r_stage[k].waddr == w_rs) begin
                w_rs_hit  = 1'b1;
                w_rs_tnew = r_stage[k].tnew;
            end
            if (r_stage[k].regwrite && r_stage[k].waddr == w_rt) begin
                w_rt_hit  = 1'b1;
                w_rt_tnew = r_stage[k].tnew;
            end
        end
        w_hazard = bus.valid_D &&
                   ((w_rs_use && w_rs != 5'd0 && w_rs_hit && w_rs_tnew > w_rs_tuse) ||
                    (w_rt_use && w_rt != 5'd0 && w_rt_hit && w_rt_tnew > w_rt_tuse));
    end

    assign w_stall     = w_hazard | bus.stall_ext;
    assign bus.stall_D = w_stall;

    // Stage 0 takes D or a bubble; later stages always shift, Tnew saturates at 0.
    always_comb begin
        w_next[0] = (bus.flush_E || w_stall || !bus.valid_D) ? '0 : w_dec;
        for (int k = 1; k < NSTAGE; k++) begin
            w_next[k] = r_stage[k-1];
            if (r_stage[k-1].tnew != '0)
                w_next[k].tnew = r_stage[k-1].tnew - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++)
                r_stage[k] <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++)
                r_stage[k] <= w_next[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_out
            assign bus.instr_s[gi*32 +: 32]  = r_stage[gi].instr;
            assign bus.regwrite_s[gi]        = r_stage[gi].regwrite;
            assign bus.waddr_s[gi*5 +: 5]    = r_stage[gi].waddr;
            assign bus.tnew_s[gi*TW +: TW]   = r_stage[gi].tnew;
        end
    endgenerate

    assign bus.memwrite_M = r_stage[MEM_STAGE].memwrite;
    assign bus.memtoreg_M = r_stage[MEM_STAGE].memtoreg;
    assign bus.size_M     = r_stage[MEM_STAGE].size;
    assign bus.ldsign_M   = r_stage[MEM_STAGE].ldsign;
    assign bus.link_M     = r_stage[MEM_STAGE].link;
endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
    localparam int NS = 3;
    localparam int MS = 1;
    localparam int TW = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic        v, se, fl, st;
        logic        rw;
        logic [4:0]  wa;
        logic [1:0]  tn;
        logic        mw, mr;
        logic [1:0]  sz;
        logic        ls, lk;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        rw;
        logic [4:0]  wa;
        logic [1:0]  tn;
        logic        mw, mr;
        logic [1:0]  sz;
        logic        ls, lk;
    } stg_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.NSTAGE(NS), .TW(TW)) bus();
    ctrl_pipe #(.NSTAGE(NS), .MEM_STAGE(MS), .TW(TW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    vec_t tbl [32];
    int   nv  = 0;
    stg_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic add_vec(input logic [31:0] instr, input logic v, input logic se,
                           input logic fl, input logic st, input logic rw,
                           input logic [4:0] wa, input logic [1:0] tn, input logic mw,
                           input logic mr, input logic [1:0] sz, input logic ls,
                           input logic lk);
        tbl[nv] = '{instr, v, se, fl, st, rw, wa, tn, mw, mr, sz, ls, lk};
        nv++;
    endtask

    task automatic chk_stages(input int tag);
        logic [1:0] t;
        for (int k = 0; k < NS; k++) begin
            t = (exp_q[k].tn > 2'(k)) ? exp_q[k].tn - 2'(k) : 2'd0;
            chk($sformatf("v%0d instr_s[%0d]", tag, k), bus.instr_s[k*32 +: 32], exp_q[k].instr);
            chk($sformatf("v%0d regwrite_s[%0d]", tag, k), 32'(bus.regwrite_s[k]), 32'(exp_q[k].rw));
            chk($sformatf("v%0d waddr_s[%0d]", tag, k), 32'(bus.waddr_s[k*5 +: 5]), 32'(exp_q[k].wa));
            chk($sformatf("v%0d tnew_s[%0d]", tag, k), 32'(bus.tnew_s[k*TW +: TW]), 32'(t));
        end
        chk($sformatf("v%0d memwrite_M", tag), 32'(bus.memwrite_M), 32'(exp_q[MS].mw));
        chk($sformatf("v%0d memtoreg_M", tag), 32'(bus.memtoreg_M), 32'(exp_q[MS].mr));
        chk($sformatf("v%0d size_M", tag), 32'(bus.size_M), 32'(exp_q[MS].sz));
        chk($sformatf("v%0d ldsign_M", tag), 32'(bus.ldsign_M), 32'(exp_q[MS].ls));
        chk($sformatf("v%0d link_M", tag), 32'(bus.link_M), 32'(exp_q[MS].lk));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " instr_s"}, 32'(bus.instr_s != '0), 32'd0);
        chk({tag, " regwrite_s"}, 32'(bus.regwrite_s), 32'd0);
        chk({tag, " waddr_s"}, 32'(bus.waddr_s), 32'd0);
        chk({tag, " tnew_s"}, 32'(bus.tnew_s), 32'd0);
        chk({tag, " mem_M"}, 32'({bus.memwrite_M, bus.memtoreg_M, bus.size_M,
                                  bus.ldsign_M, bus.link_M}), 32'd0);
    endtask

    initial begin
        stg_t e;
        logic [31:0] lw8, addu10, beq10, lw12, bne12, ori8, sw8, lw31, beq31;
        logic [31:0] jalr17, ori20;
        lw8    = enc_i(6'h23, 5'd9, 5'd8, 16'd0);
        addu10 = enc_r(5'd8, 5'd11, 5'd10, 6'h21);
        beq10  = enc_i(6'h04, 5'd10, 5'd0, 16'd0);
        lw12   = enc_i(6'h23, 5'd0, 5'd12, 16'd4);
        bne12  = enc_i(6'h05, 5'd12, 5'd1, 16'd0);
        ori8   = enc_i(6'h0d, 5'd0, 5'd8, 16'd5);
        sw8    = enc_i(6'h2b, 5'd0, 5'd8, 16'd0);
        lw31   = enc_i(6'h23, 5'd0, 5'd31, 16'd0);
        beq31  = enc_i(6'h04, 5'd31, 5'd0, 16'd0);
        jalr17 = enc_r(5'd16, 5'd0, 5'd17, 6'h09);
        ori20  = enc_i(6'h0d, 5'd0, 5'd20, 16'd1);

        //          instr                          v  se fl st  rw wa  tn mw mr sz ls lk
        add_vec(lw8,                               1, 0, 0, 0,  1, 8,  2, 0, 1, 2, 0, 0);
        add_vec(addu10,                            1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(addu10,                            1, 0, 0, 0,  1, 10, 1, 0, 0, 0, 0, 0);
        add_vec(beq10,                             1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(beq10,                             1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(lw12,                              1, 0, 0, 0,  1, 12, 2, 0, 1, 2, 0, 0);
        add_vec(bne12,                             1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(bne12,                             1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(bne12,                             1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(lw8,                               1, 0, 0, 0,  1, 8,  2, 0, 1, 2, 0, 0);
        add_vec(ori8,                              1, 0, 0, 0,  1, 8,  1, 0, 0, 0, 0, 0);
        add_vec(sw8,                               1, 0, 0, 0,  0, 0,  0, 1, 0, 2, 0, 0);
        add_vec(lw31,                              1, 0, 0, 0,  1, 31, 2, 0, 1, 2, 0, 0);
        add_vec(32'h0C00_0010,                     1, 0, 0, 0,  1, 31, 0, 0, 0, 0, 0, 1);
        add_vec(beq31,                             1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(enc_r(5'd1, 5'd2, 5'd0, 6'h21),    1, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);
        add_vec(enc_r(5'd0, 5'd0, 5'd14, 6'h21),   1, 0, 0, 0,  1, 14, 1, 0, 0, 0, 0, 0);
        add_vec(enc_i(6'h25, 5'd0, 5'd15, 16'd0),  1, 0, 0, 0,  1, 15, 2, 0, 1, 1, 0, 0);
        add_vec(enc_i(6'h28, 5'd0, 5'd15, 16'd0),  1, 0, 0, 0,  0, 0,  0, 1, 0, 0, 0, 0);
        add_vec(enc_i(6'h20, 5'd0, 5'd16, 16'd0),  1, 0, 0, 0,  1, 16, 2, 0, 1, 0, 1, 0);
        add_vec(jalr17,                            1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(jalr17,                            1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(jalr17,                            1, 0, 0, 0,  1, 17, 0, 0, 0, 0, 0, 1);
        add_vec(enc_r(5'd17, 5'd17, 5'd18, 6'h21), 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(enc_i(6'h01, 5'd5, 5'd17, 16'd0),  1, 0, 0, 0,  1, 31, 0, 0, 0, 0, 0, 1);
        add_vec(ori20,                             1, 0, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(ori20,                             1, 1, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(ori20,                             1, 1, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(ori20,                             1, 0, 0, 0,  1, 20, 1, 0, 0, 0, 0, 0);
        add_vec(32'h0,                             0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(32'h0,                             0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(32'h0,                             0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);

        bus.instr_D = '0; bus.valid_D = 1'b0; bus.stall_ext = 1'b0; bus.flush_E = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset stall_D", 32'(bus.stall_D), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < NS; k++) exp_q.push_front('0);

        for (int i = 0; i < nv; i++) begin
            bus.instr_D   = tbl[i].instr;
            bus.valid_D   = tbl[i].v;
            bus.stall_ext = tbl[i].se;
            bus.flush_E   = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d stall_D", i), 32'(bus.stall_D), 32'(tbl[i].st));
            $display("vec %0d instr=%08h v=%b se=%b fl=%b stall_D=%b", i, tbl[i].instr,
                     tbl[i].v, tbl[i].se, tbl[i].fl, bus.stall_D);
            if (tbl[i].st || tbl[i].fl || !tbl[i].v) e = '0;
            else e = '{tbl[i].instr, tbl[i].rw, tbl[i].wa, tbl[i].tn, tbl[i].mw,
                       tbl[i].mr, tbl[i].sz, tbl[i].ls, tbl[i].lk};
            exp_q.push_front(e);
            @(posedge clk);
            #1;
            if (exp_q.size() > NS) void'(exp_q.pop_back());
            chk_stages(i);
        end

        // Reset mid-stream: lw $8 sitting in stage 1 must vanish without a clock edge.
        bus.instr_D = lw8; bus.valid_D = 1'b1; bus.stall_ext = 1'b0; bus.flush_E = 1'b0;
        @(posedge clk); #1;
        bus.valid_D = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset regwrite_s[1]", 32'(bus.regwrite_s[1]), 32'd1);
        chk("pre-reset tnew_s[1]", 32'(bus.tnew_s[TW +: TW]), 32'd1);
        chk("pre-reset memtoreg_M", 32'(bus.memtoreg_M), 32'd1);
        $display("async reset asserted mid-cycle with lw in stage 1");
        #2;
        reset = 1'b1;
        bus.stall_ext = 1'b1;
        #1;
        chk_all_zero("async reset");
        chk("reset stall_D follows stall_ext=1", 32'(bus.stall_D), 32'd1);
        bus.stall_ext = 1'b0;
        #1;
        chk("reset stall_D follows stall_ext=0", 32'(bus.stall_D), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
